// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        FILL,
        DONE
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W:1];
    endfunction

    // Index and tag come back full width; callers size-cast to their own field width.
    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] addr,
                                                     input int index_w);
        return (addr >> (OFFSET_W + 1)) & ((ADDR_W'(1) << index_w) - ADDR_W'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr,
                                                   input int index_w);
        return addr >> (OFFSET_W + 1 + index_w);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one word write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  idx,
    input  logic [OFFSET_W-1:0] rd_word,
    output logic [DATA_W-1:0]   rd_data,
    output logic [TAG_W-1:0]    tag,
    output logic                valid,
    output logic                dirty,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                fill_done,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic                dirty_set
);

    localparam int LINES = 1 << INDEX_W;

    logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_bits;
    logic [LINES-1:0]  dirty_bits;

    assign rd_data = data_mem[idx][rd_word];
    assign tag     = tag_mem[idx];
    assign valid   = valid_bits[idx];
    assign dirty   = dirty_bits[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            if (fill_done) begin
                valid_bits[idx] <= 1'b1;
                dirty_bits[idx] <= 1'b0;
            end
            if (dirty_set) begin
                dirty_bits[idx] <= 1'b1;
            end
        end
    end

    // Data and tags carry no reset; a cleared valid bit makes them don't-care.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[idx][wr_word] <= wr_data;
        end
        if (fill_done) begin
            tag_mem[idx] <= fill_tag;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller below the memory stage.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 1;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    state_t state, next_state;
    logic [OFFSET_W-1:0] word_cnt;

    logic [MEM_LAT-1:0]  fill_vld_p;
    logic [OFFSET_W-1:0] fill_word_p [MEM_LAT];

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    req_tag;
    logic                req, illegal, hit;
    logic                fill_exit;
    logic [OFFSET_W-1:0] fill_exit_word;

    logic [OFFSET_W-1:0] arr_rd_word;
    logic [DATA_W-1:0]   arr_rd_data;
    logic [TAG_W-1:0]    line_tag;
    logic                line_valid, line_dirty;
    logic                arr_we, fill_done, dirty_set;
    logic [OFFSET_W-1:0] arr_wr_word;
    logic [DATA_W-1:0]   arr_wr_data;
    logic                mem_accept, rd_accept;

    assign offset  = addr_offset(Addr);
    assign idx     = INDEX_W'(addr_index(Addr, INDEX_W));
    assign req_tag = TAG_W'(addr_tag(Addr, INDEX_W));
    assign req     = Rd | Wr;
    assign illegal = (Rd & Wr) | (req & Addr[0]);
    assign hit     = line_valid && (line_tag == req_tag);

    assign fill_exit      = fill_vld_p[MEM_LAT-1];
    assign fill_exit_word = fill_word_p[MEM_LAT-1];

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .rd_word   (arr_rd_word),
        .rd_data   (arr_rd_data),
        .tag       (line_tag),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .wr_en     (arr_we),
        .wr_word   (arr_wr_word),
        .wr_data   (arr_wr_data),
        .fill_done (fill_done),
        .fill_tag  (req_tag),
        .dirty_set (dirty_set)
    );

    always_comb begin
        next_state  = state;
        DataOut     = '0;
        Done        = 1'b0;
        Stall       = 1'b0;
        CacheHit    = 1'b0;
        err         = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        arr_rd_word = offset;
        arr_we      = 1'b0;
        arr_wr_word = offset;
        arr_wr_data = DataIn;
        fill_done   = 1'b0;
        dirty_set   = 1'b0;
        mem_accept  = 1'b0;
        rd_accept   = 1'b0;

        case (state)
            IDLE: begin
                if (illegal) begin
                    err = 1'b1;
                end else if (req && hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (Rd) DataOut = arr_rd_data;
                    if (Wr) begin
                        arr_we    = 1'b1;
                        dirty_set = 1'b1;
                    end
                end else if (req) begin
                    Stall      = 1'b1;
                    next_state = (line_valid && line_dirty) ? WB : RD;
                end
            end
            WB: begin
                Stall       = 1'b1;
                arr_rd_word = word_cnt;
                mem_wr      = 1'b1;
                mem_addr    = {line_tag, idx, word_cnt, 1'b0};
                mem_wdata   = arr_rd_data;
                mem_accept  = !mem_stall;
                if (mem_accept && word_cnt == LAST_WORD) next_state = RD;
            end
            RD: begin
                Stall      = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = {req_tag, idx, word_cnt, 1'b0};
                mem_accept = !mem_stall;
                rd_accept  = mem_accept;
                if (mem_accept && word_cnt == LAST_WORD) next_state = FILL;
            end
            FILL: begin
                Stall = 1'b1;
                if (fill_exit && fill_exit_word == LAST_WORD) begin
                    fill_done  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Rd) DataOut = arr_rd_data;
                if (Wr) begin
                    arr_we    = 1'b1;
                    dirty_set = 1'b1;
                end
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Returning read data has priority on the write port; it never overlaps a store.
        if (fill_exit && (state == RD || state == FILL)) begin
            arr_we      = 1'b1;
            arr_wr_word = fill_exit_word;
            arr_wr_data = mem_rdata;
        end

        if (rst) begin
            next_state = IDLE;
            DataOut    = '0;
            Done       = 1'b0;
            Stall      = 1'b0;
            CacheHit   = 1'b0;
            err        = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
            mem_wr     = 1'b0;
            mem_rd     = 1'b0;
            arr_we     = 1'b0;
            fill_done  = 1'b0;
            dirty_set  = 1'b0;
            mem_accept = 1'b0;
            rd_accept  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state <= next_state;
            if (mem_accept) word_cnt <= word_cnt + 1'b1;
        end
    end

    // p0..p(MEM_LAT-1): one stage per cycle of main-memory read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_vld_p <= '0;
        end else begin
            fill_vld_p[0] <= rd_accept;
            for (int i = 1; i < MEM_LAT; i++) fill_vld_p[i] <= fill_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        fill_word_p[0] <= word_cnt;
        for (int i = 1; i < MEM_LAT; i++) fill_word_p[i] <= fill_word_p[i-1];
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: transaction-level cache model with a per-cycle compare plus directed scenarios.
module tb_dcache_ctrl;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, CacheHit, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd, mem_stall;

    dcache_ctrl #(.INDEX_W(5), .MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_stall (mem_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ctrl(input string name, input logic d, input logic s, input logic h,
                            input logic e, input logic mr, input logic mw);
        chk({name, ".Done"},     16'(Done),     16'(d));
        chk({name, ".Stall"},    16'(Stall),    16'(s));
        chk({name, ".CacheHit"}, 16'(CacheHit), 16'(h));
        chk({name, ".err"},      16'(err),      16'(e));
        chk({name, ".mem_rd"},   16'(mem_rd),   16'(mr));
        chk({name, ".mem_wr"},   16'(mem_wr),   16'(mw));
    endtask

    // Main memory: untouched words read as addr ^ 0xA5A5.
    logic [15:0] mem [int];

    function automatic logic [15:0] rdmem(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a ^ 16'hA5A5;
    endfunction

    logic [MEM_LAT-1:0] pv = '0;
    logic [15:0]        pa [MEM_LAT];
    logic [15:0]        rlog [$];
    logic [15:0]        wlog_a [$];
    logic [15:0]        wlog_d [$];

    initial mem_rdata = 16'h0;

    always @(posedge clk) begin
        if (mem_wr && !mem_stall) begin
            mem[int'(mem_addr)] = mem_wdata;
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
        if (mem_rd && !mem_stall) rlog.push_back(mem_addr);
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = mem_rd && !mem_stall;
        pa[0] = mem_addr;
        #1 mem_rdata = pv[MEM_LAT-1] ? rdmem(pa[MEM_LAT-1]) : 16'h0;
    end

    // Cache model: what the cache holds, plus the memory transfers a miss still owes.
    typedef struct packed {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] data;
    } op_t;

    bit          m_valid [32];
    bit          m_dirty [32];
    logic [7:0]  m_tag   [32];
    logic [15:0] m_data  [32][4];
    op_t         ops [$];
    bit          busy = 1'b0;
    int          drain;
    int          m_ix, m_ofs;
    logic [7:0]  m_tg;
    logic [15:0] m_base, v_base;
    op_t         op;

    always @(negedge clk) begin
        m_ix  = int'(Addr[7:3]);
        m_ofs = int'(Addr[2:1]);
        m_tg  = Addr[15:8];
        m_base = Addr & 16'hFFF8;
        if (rst) begin
            chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.DataOut", DataOut, 16'h0);
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            ops.delete();
            busy = 1'b0;
        end else if (!busy) begin
            if (!Rd && !Wr) begin
                chk_ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("idle.DataOut", DataOut, 16'h0);
            end else if ((Rd && Wr) || Addr[0]) begin
                chk_ctrl("illegal", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end else if (m_valid[m_ix] && m_tag[m_ix] == m_tg) begin
                chk_ctrl("hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                if (Rd) chk("hit.DataOut", DataOut, m_data[m_ix][m_ofs]);
                else begin
                    m_data[m_ix][m_ofs] = DataIn;
                    m_dirty[m_ix] = 1'b1;
                end
            end else begin
                chk_ctrl("miss", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                v_base = {m_tag[m_ix], 8'h00} + (m_base & 16'h00F8);
                if (m_valid[m_ix] && m_dirty[m_ix]) begin
                    for (int w = 0; w < 4; w++) begin
                        op.is_wr = 1'b1;
                        op.addr  = v_base + 16'(2 * w);
                        op.data  = m_data[m_ix][w];
                        ops.push_back(op);
                    end
                end
                for (int w = 0; w < 4; w++) begin
                    op.is_wr = 1'b0;
                    op.addr  = m_base + 16'(2 * w);
                    op.data  = 16'h0;
                    ops.push_back(op);
                    m_data[m_ix][w] = rdmem(m_base + 16'(2 * w));
                end
                m_tag[m_ix]   = m_tg;
                m_valid[m_ix] = 1'b1;
                m_dirty[m_ix] = 1'b0;
                busy  = 1'b1;
                drain = MEM_LAT;
            end
        end else if (ops.size() > 0) begin
            op = ops[0];
            chk_ctrl("xfer", 1'b0, 1'b1, 1'b0, 1'b0, !op.is_wr, op.is_wr);
            chk("xfer.mem_addr", mem_addr, op.addr);
            if (op.is_wr) chk("xfer.mem_wdata", mem_wdata, op.data);
            if (!mem_stall) void'(ops.pop_front());
        end else if (drain > 0) begin
            chk_ctrl("fill", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            drain--;
        end else begin
            chk_ctrl("done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (Rd) chk("done.DataOut", DataOut, m_data[m_ix][m_ofs]);
            else begin
                m_data[m_ix][m_ofs] = DataIn;
                m_dirty[m_ix] = 1'b1;
            end
            busy = 1'b0;
        end
    end

    // Drives one request from posedge+1 until Done or err; returns cycles from request to completion.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int st_at, input int st_len,
                          output int lat, output logic [15:0] dout, output logic hitf, output logic errf);
        int k = 0;
        bit fin = 1'b0;
        lat = -1; dout = 16'h0; hitf = 1'b0; errf = 1'b0;
        rlog.delete(); wlog_a.delete(); wlog_d.delete();
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        mem_stall = (k >= st_at && k < st_at + st_len);
        while (!fin && k < 60) begin
            @(negedge clk);
            if (Done || err) begin
                fin = 1'b1; lat = k; dout = DataOut; hitf = CacheHit; errf = err;
            end
            @(posedge clk); #1;
            k++;
            mem_stall = (k >= st_at && k < st_at + st_len);
        end
        Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0; mem_stall = 1'b0;
    endtask

    int          lat;
    logic [15:0] dout;
    logic        hf, ef;

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0; mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        access(1'b1, 1'b0, 16'h0010, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("cold.lat", 16'(lat), 16'd7);
        chk("cold.hit", 16'(hf), 16'd0);
        chk("cold.data", dout, 16'hA5B5);
        chk("cold.nreads", 16'(rlog.size()), 16'd4);
        if (rlog.size() == 4) begin
            chk("cold.rd0", rlog[0], 16'h0010);
            chk("cold.rd1", rlog[1], 16'h0012);
            chk("cold.rd3", rlog[3], 16'h0016);
        end

        access(1'b1, 1'b0, 16'h0014, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("rehit.lat", 16'(lat), 16'd0);
        chk("rehit.hit", 16'(hf), 16'd1);
        chk("rehit.data", dout, 16'hA5B1);
        chk("rehit.nreads", 16'(rlog.size()), 16'd0);

        access(1'b1, 1'b1, 16'h0014, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("rdwr.err", 16'(ef), 16'd1);
        access(1'b1, 1'b0, 16'h0011, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("oddrd.err", 16'(ef), 16'd1);
        access(1'b0, 1'b1, 16'h0015, 16'h1234, 0, 0, lat, dout, hf, ef);
        chk("oddwr.err", 16'(ef), 16'd1);
        access(1'b1, 1'b0, 16'h0014, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("posterr.hit", 16'(hf), 16'd1);
        chk("posterr.data", dout, 16'hA5B1);

        access(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0, 0, lat, dout, hf, ef);
        chk("sthit.lat", 16'(lat), 16'd0);
        chk("sthit.hit", 16'(hf), 16'd1);

        access(1'b1, 1'b0, 16'h0112, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("dirty.lat", 16'(lat), 16'd11);
        chk("dirty.data", dout, 16'hA4B7);
        chk("dirty.nwrites", 16'(wlog_a.size()), 16'd4);
        if (wlog_a.size() == 4) begin
            chk("dirty.wa0", wlog_a[0], 16'h0010);
            chk("dirty.wa1", wlog_a[1], 16'h0012);
            chk("dirty.wd1", wlog_d[1], 16'hBEEF);
            chk("dirty.wd2", wlog_d[2], 16'hA5B1);
            chk("dirty.wa3", wlog_a[3], 16'h0016);
        end
        if (rlog.size() == 4) begin
            chk("dirty.rd0", rlog[0], 16'h0110);
            chk("dirty.rd3", rlog[3], 16'h0116);
        end else chk("dirty.nreads", 16'(rlog.size()), 16'd4);

        access(1'b1, 1'b0, 16'h0200, 16'h0, 2, 3, lat, dout, hf, ef);
        chk("rdstall.lat", 16'(lat), 16'd10);
        chk("rdstall.data", dout, 16'hA7A5);
        chk("rdstall.nreads", 16'(rlog.size()), 16'd4);
        if (rlog.size() == 4) begin
            chk("rdstall.rd1", rlog[1], 16'h0202);
            chk("rdstall.rd2", rlog[2], 16'h0204);
            chk("rdstall.rd3", rlog[3], 16'h0206);
        end

        access(1'b0, 1'b1, 16'h0306, 16'h5555, 0, 0, lat, dout, hf, ef);
        chk("stmiss.lat", 16'(lat), 16'd7);
        chk("stmiss.hit", 16'(hf), 16'd0);
        access(1'b1, 1'b0, 16'h0306, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("stmiss.readback", dout, 16'h5555);

        access(1'b0, 1'b1, 16'h0204, 16'h7777, 2, 1, lat, dout, hf, ef);
        chk("wbstall.lat", 16'(lat), 16'd12);
        chk("wbstall.nwrites", 16'(wlog_a.size()), 16'd4);
        if (wlog_a.size() == 4) begin
            chk("wbstall.wa3", wlog_a[3], 16'h0306);
            chk("wbstall.wd3", wlog_d[3], 16'h5555);
            chk("wbstall.wd0", wlog_d[0], 16'hA6A5);
        end
        access(1'b1, 1'b0, 16'h0204, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("wbstall.readback", dout, 16'h7777);

        Rd = 1'b1; Addr = 16'h0010;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; Rd = 1'b0; Addr = 16'h0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst.Stall", 16'(Stall), 16'd0);
        chk("postrst.Done", 16'(Done), 16'd0);
        chk("postrst.mem_rd", 16'(mem_rd), 16'd0);
        @(posedge clk); #1;

        access(1'b1, 1'b0, 16'h0010, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("rstmiss.lat", 16'(lat), 16'd7);
        chk("rstmiss.hit", 16'(hf), 16'd0);
        chk("rstmiss.data", dout, 16'hA5B5);
        access(1'b1, 1'b0, 16'h0012, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("wbpersist.hit", 16'(hf), 16'd1);
        chk("wbpersist.data", dout, 16'hBEEF);
        access(1'b1, 1'b0, 16'h0204, 16'h0, 0, 0, lat, dout, hf, ef);
        chk("dirtylost.lat", 16'(lat), 16'd7);
        chk("dirtylost.data", dout, 16'hA7A1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with its controller FSM, placed directly below the memory stage.
- Consumes the memory stage's load/store request and produces the Done/Stall/CacheHit/err handshake that the memory stage already forwards to the pipeline.
- On a miss it writes back a dirty victim line and refills the line over a pipelined, fixed-latency main-memory port.

Parameters:
- INDEX_W, 5: index bits; the cache holds 2^INDEX_W lines of 4 x 16-bit words.
- MEM_LAT, 2: cycles from an accepted memory read to valid mem_rdata.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- Addr  in  16  byte address; bit0 must be 0
- DataIn  in  16  store data
- Rd  in  1  load request
- Wr  in  1  store request
- DataOut  out  16  load data, valid while Done=1
- Done  out  1  access complete this cycle
- Stall  out  1  miss in progress; requester must hold Addr/DataIn/Rd/Wr stable
- CacheHit  out  1  Done is a first-look hit
- err  out  1  illegal request this cycle
- mem_addr  out  16  main-memory word address (byte address, bit0=0)
- mem_wdata  out  16  writeback data
- mem_wr  out  1  memory write
- mem_rd  out  1  memory read
- mem_rdata  in  16  read data, MEM_LAT cycles after accept
- mem_stall  in  1  memory busy; mem_rd/mem_wr not accepted this cycle

Behaviour:
- Address split: offset=Addr[2:1], index=Addr[2+INDEX_W:3], tag=remaining upper bits (8 bits at default).
- Reset: all outputs 0 and FSM in IDLE. All valid and dirty bits cleared. Fill tracker cleared. Reset mid-miss abandons the miss and loses in-flight memory data.
- FSM states: IDLE, WB, RD, FILL, DONE.
- IDLE hit (valid and tag match): Done=1 and CacheHit=1 in the same cycle (0 latency). DataOut=word on a load. A store writes the word and sets dirty at the clock edge.
- IDLE miss: Stall=1 from the request cycle. Go to WB if the victim is valid and dirty, else to RD.
- WB: issue 4 writes, words 0..3, using the victim tag. Each write advances only when mem_stall=0. After word 3 is accepted, go to RD.
- RD: issue 4 reads, words 0..3 of the requested line. Each read advances only when mem_stall=0. A MEM_LAT-deep shift register carries valid + word index for each accepted read. After word 3 is issued, go to FILL.
- Fill capture: whenever a tracker entry exits, mem_rdata is written to that word. This happens in RD and FILL.
- FILL: when all 4 words are captured, write tag, set valid, clear dirty, then go to DONE.
- DONE (one cycle): Done=1, CacheHit=0, Stall=0. Load returns the filled word. A store merges DataIn and sets dirty. Next state is IDLE.
- Stall is 1 in the IDLE-miss cycle and in all of WB, RD and FILL; it is 0 in DONE.
- Latency, default MEM_LAT, mem_stall=0, request in cycle 0:
  - clean miss: Done in cycle 7
  - dirty miss: Done in cycle 11
  - each mem_stall cycle during WB or RD adds 1
- Illegal request in IDLE: Rd&Wr, or (Rd|Wr)&Addr[0]. err=1 that cycle, Done=0, no state or array change.
- A request change while Stall=1 is not supported and not checked. Rd=Wr=0 in IDLE: all outputs 0.
- mem_rd and mem_wr are never asserted together. Both are 0 in IDLE and DONE.

Decomposition:
- Package dcache_pkg holds:
  - the state encoding
  - LINE_WORDS=4 and OFFSET_W=2
  - the address-field slicing functions
- Sub-module dcache_array holds the tag/valid/dirty/data storage:
  - one combinational read port (index, word)
  - one synchronous word write port
  - tag/valid/dirty update controls
  - synchronous clear of valid on rst

Test Plan:
- Cold load 0x0010 after reset -> Stall cycles 0-6; mem_rd addresses 0x0010, 0x0012, 0x0014, 0x0016 in cycles 1-4; Done=1, CacheHit=0 in cycle 7; DataOut=mem word at 0x0010.
- Repeat load 0x0014 -> Done=1, CacheHit=1 in the request cycle; DataOut=mem word at 0x0014; no mem_rd.
- Store 0xBEEF to 0x0012 (hit), then load 0x0112 (same index, tag 0x01):
  - mem_wr at 0x0010..0x0016 in cycles 1-4, carrying 0xBEEF at 0x0012
  - reads of 0x0110..0x0116 follow
  - Done in cycle 11
- Clean miss with mem_stall=1 for 3 cycles during RD -> no duplicate or skipped addresses; Done in cycle 10.
- Rd=Wr=1, and separately Rd with Addr=0x0011 -> err=1, Done=0, Stall=0; next legal hit is unaffected.
- rst pulsed in FILL -> next cycle all outputs 0 and FSM in IDLE; a subsequent load of the same address misses (valid was cleared).
